pcircle: RTL and testbench
==========================

PCIRCLE -- requirements
Module: pcircle

Interface
REQ-001 Parameter SCREEN_W, default 160, visible width in pixels.
REQ-002 Parameter SCREEN_H, default 120, visible height in pixels.
REQ-003 Parameter X_W, default 8, width of x coordinates and radius.
REQ-004 Parameter Y_W, default 7, width of y coordinates.
REQ-005 Parameter COLOUR_W, default 3, width of colour.
REQ-006 The block SHALL use one clock and a synchronous, active-low reset on the ports below.
- clk  in  1  clock, all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a draw; level-held by the requester.
- fill  in  1  1 = filled disc, 0 = outline (used only when PCIRCLE_FILL_EN is defined).
- colour  in  COLOUR_W  pixel colour.
- centre_x  in  X_W  centre column.
- centre_y  in  Y_W  centre row.
- radius  in  X_W  radius, unsigned.
- done  out  1  draw complete.
- vga_x  out  X_W  pixel column.
- vga_y  out  Y_W  pixel row.
- vga_colour  out  COLOUR_W  pixel colour.
- vga_plot  out  1  pixel write strobe.

Function
REQ-007 The FSM SHALL have states IDLE, INIT, PLOT, DONE.
REQ-008 IDLE: when start=1, latch colour, centre_x, centre_y, radius and fill, then go to INIT. Inputs SHALL be ignored after latching until the next IDLE.
REQ-009 INIT (1 cycle, vga_plot=0): set offset_y=0, offset_x=radius, crit=1-radius, then go to PLOT.
REQ-010 Outline PLOT: each iteration SHALL take exactly 8 cycles, one pixel per cycle, in this order: (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-ox,cy+oy), (cx-oy,cy+ox), (cx-ox,cy-oy), (cx-oy,cy-ox), (cx+ox,cy-oy), (cx+oy,cy-ox).
REQ-011 On the last cycle of each iteration, the offsets SHALL update as follows: oy+=1. If crit<=0, crit+=2*oy+1 using the new oy. Otherwise ox-=1 and crit+=2*(oy-ox)+1 using the new values.
REQ-012 Iterations SHALL continue while oy<=ox, then the FSM goes to DONE.
REQ-013 All offset and coordinate arithmetic SHALL be signed, at least max(X_W,Y_W)+2 bits wide, and SHALL never truncate before the clip test.
REQ-014 Clipping: a pixel with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H SHALL still consume its cycle but drive vga_plot=0. vga_x and vga_y SHALL never wrap to an on-screen value with vga_plot=1.
REQ-015 vga_colour SHALL equal the latched colour on every PLOT cycle.
REQ-016 DONE: done=1 and vga_plot=0. The FSM stays in DONE while start=1, and returns to IDLE with done=0 on the edge after start=0.
REQ-017 radius=0 SHALL produce one iteration: 8 plot cycles, all at (cx,cy).
REQ-018 vga_plot SHALL be 0 in IDLE, INIT and DONE.

Reset
REQ-019 rst_n=0 at any rising edge, including mid-draw, SHALL force IDLE with done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-020 An interrupted draw SHALL NOT resume. A new draw starts only when start is seen in IDLE after reset release.

Configuration
REQ-021 Macro PCIRCLE_FILL_EN defined:
- fill=1 replaces REQ-010 per iteration with four horizontal spans, one pixel per cycle, left to right.
- Span rows and extents, in order: row cy+oy over cx-ox..cx+ox; row cy-oy over the same; row cy+ox over cx-oy..cx+oy; row cy-ox over the same.
- The offset update of REQ-011 SHALL occur on the last pixel of the fourth span.
- Clipping per REQ-014 applies to every span pixel.
REQ-022 Macro PCIRCLE_FILL_EN undefined: the fill port SHALL exist but be ignored; behaviour is outline only.

Verification
REQ-023 Radius 0: r=0, centre (80,60), start=1 -> exactly 8 cycles with vga_plot=1, all at (80,60); then done=1.
REQ-024 Outline first iteration: r=40, centre (80,60), colour=2, fill=0 -> first 8 plotted pixels are (120,60), (80,100), (40,60), (80,100), (40,60), (80,20), (120,60), (80,20), each with vga_colour=2. The total plot-cycle count SHALL match a reference model exactly.
REQ-025 Clipping: r=10, centre (5,5) -> no cycle with vga_plot=1 has x>=160 or y>=120. The pixel (-5,5) is suppressed. The cycle count SHALL equal the unclipped count.
REQ-026 Reset mid-draw: r=40 draw, rst_n=0 for 1 cycle during iteration 3 -> next cycle vga_plot=0 and done=0. With start held 1 after release, a full fresh draw restarts from (120,60).
REQ-027 Done handshake: start held 1 after done -> done stays 1 for 20 cycles with no plots. Then start=0 -> done=0 next cycle. Then start=1 -> new draw.
REQ-028 Fill: with PCIRCLE_FILL_EN defined, r=2, centre (10,10), fill=1 -> the set of plotted pixels equals every (x,y) with |y-10|<=2 lying between the span extents of REQ-021, rows 8..12. Without the macro, the same stimulus gives the outline of REQ-010.

Source files
------------

// File: rtl/pcircle.sv
// pcircle: midpoint circle rasteriser driving a pixel-plot interface.
// Optional filled-disc mode is compiled in with `define PCIRCLE_FILL_EN.
// Outputs are registered and computed from next-state values, so the pixel on
// vga_x/vga_y is the one belonging to the current PLOT cycle.
module pcircle #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                fill,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [X_W-1:0]      radius,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    // Two guard bits keep centre +/- offset exact and signed.
    localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 2;
    // Decision variable gets extra headroom for the 2*(oy-ox) term.
    localparam int KW = CW + 2;

    localparam logic signed [CW-1:0] SW_S = CW'(SCREEN_W);
    localparam logic signed [CW-1:0] SH_S = CW'(SCREEN_H);

    typedef enum logic [1:0] {StIdle, StInit, StPlot, StDone} state_e;

    state_e                 state_q, state_d;
    logic [COLOUR_W-1:0]    colour_q, colour_d;
    logic signed [CW-1:0]   cx_q, cx_d;
    logic signed [CW-1:0]   cy_q, cy_d;
    logic signed [CW-1:0]   r_q, r_d;
    logic                   fill_q, fill_d;
    logic signed [CW-1:0]   ox_q, ox_d;
    logic signed [CW-1:0]   oy_q, oy_d;
    logic signed [KW-1:0]   crit_q, crit_d;
    logic [2:0]             step_q, step_d;
    logic [1:0]             span_q, span_d;
    logic signed [CW-1:0]   sx_q, sx_d;
    logic                   done_q, done_d;
    logic [X_W-1:0]         vga_x_q, vga_x_d;
    logic [Y_W-1:0]         vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0]    vga_colour_q, vga_colour_d;
    logic                   vga_plot_q, vga_plot_d;

    logic signed [CW-1:0]   ox_n, oy_n, ext_cur, ext_nxt, px, py;
    logic                   last;

`ifdef PCIRCLE_FILL_EN
    logic fill_in;
    assign fill_in = fill;
`else
    logic fill_in;
    logic unused_fill;
    assign fill_in     = 1'b0;
    assign unused_fill = fill;
`endif

    assign done       = done_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

    // Next-state: FSM sequencing, octant/span stepping and midpoint update.
    always_comb begin
        state_d      = state_q;
        colour_d     = colour_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        r_d          = r_q;
        fill_d       = fill_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        crit_d       = crit_q;
        step_d       = step_q;
        span_d       = span_q;
        sx_d         = sx_q;
        done_d       = done_q;
        vga_x_d      = '0;
        vga_y_d      = '0;
        vga_colour_d = '0;
        vga_plot_d   = 1'b0;
        ox_n         = ox_q;
        oy_n         = oy_q;
        ext_cur      = ox_q;
        ext_nxt      = ox_q;
        px           = '0;
        py           = '0;
        last         = 1'b0;

        case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (start) begin
                    colour_d = colour;
                    cx_d     = signed'(CW'(centre_x));
                    cy_d     = signed'(CW'(centre_y));
                    r_d      = signed'(CW'(radius));
                    fill_d   = fill_in;
                    state_d  = StInit;
                end
            end
            StInit: begin
                ox_d    = r_q;
                oy_d    = '0;
                crit_d  = KW'(1) - KW'(r_q);
                step_d  = '0;
                span_d  = '0;
                sx_d    = -r_q;
                state_d = StPlot;
            end
            StPlot: begin
                ext_cur = (span_q < 2'd2) ? ox_q : oy_q;
                last    = fill_q ? ((span_q == 2'd3) && (sx_q == oy_q)) : (step_q == 3'd7);
                if (last) begin
                    oy_n = oy_q + CW'(1);
                    if (crit_q[KW-1] || (crit_q == '0)) begin
                        ox_n   = ox_q;
                        crit_d = crit_q + (KW'(oy_n) <<< 1) + KW'(1);
                    end else begin
                        ox_n   = ox_q - CW'(1);
                        crit_d = crit_q + ((KW'(oy_n) - KW'(ox_n)) <<< 1) + KW'(1);
                    end
                    ox_d   = ox_n;
                    oy_d   = oy_n;
                    step_d = '0;
                    span_d = '0;
                    sx_d   = -ox_n;
                    if (oy_n > ox_n) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end else if (fill_q) begin
                    if (sx_q == ext_cur) begin
                        // Spans 0,1 run over +/-ox; spans 2,3 over +/-oy.
                        ext_nxt = (span_q == 2'd0) ? ox_q : oy_q;
                        span_d  = span_q + 2'd1;
                        sx_d    = -ext_nxt;
                    end else begin
                        sx_d = sx_q + CW'(1);
                    end
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pixel for the upcoming PLOT cycle, from the offsets it will hold.
        if (state_d == StPlot) begin
            if (fill_q) begin
                px = cx_q + sx_d;
                case (span_d)
                    2'd0:    py = cy_q + oy_d;
                    2'd1:    py = cy_q - oy_d;
                    2'd2:    py = cy_q + ox_d;
                    default: py = cy_q - ox_d;
                endcase
            end else begin
                case (step_d)
                    3'd0:    begin px = cx_q + ox_d; py = cy_q + oy_d; end
                    3'd1:    begin px = cx_q + oy_d; py = cy_q + ox_d; end
                    3'd2:    begin px = cx_q - ox_d; py = cy_q + oy_d; end
                    3'd3:    begin px = cx_q - oy_d; py = cy_q + ox_d; end
                    3'd4:    begin px = cx_q - ox_d; py = cy_q - oy_d; end
                    3'd5:    begin px = cx_q - oy_d; py = cy_q - ox_d; end
                    3'd6:    begin px = cx_q + ox_d; py = cy_q - oy_d; end
                    default: begin px = cx_q + oy_d; py = cy_q - ox_d; end
                endcase
            end
            vga_x_d      = px[X_W-1:0];
            vga_y_d      = py[Y_W-1:0];
            vga_colour_d = colour_q;
            // Clipped pixels keep their cycle but never strobe.
            vga_plot_d   = !px[CW-1] && (px < SW_S) && !py[CW-1] && (py < SH_S);
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            colour_q     <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            r_q          <= '0;
            fill_q       <= 1'b0;
            ox_q         <= '0;
            oy_q         <= '0;
            crit_q       <= '0;
            step_q       <= '0;
            span_q       <= '0;
            sx_q         <= '0;
            done_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            colour_q     <= colour_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            r_q          <= r_d;
            fill_q       <= fill_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            crit_q       <= crit_d;
            step_q       <= step_d;
            span_q       <= span_d;
            sx_q         <= sx_d;
            done_q       <= done_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

endmodule

// File: tb/tb_pcircle.sv
// Directed bench for pcircle: reset, outline, handshake, radius 0, clipping,
// mid-draw reset and the fill/outline r=2 case.
module tb_pcircle;

    logic       clk = 1'b0;
    logic       rst_n, start, fill;
    logic [2:0] colour;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int errors = 0;
    int checks = 0;
    int pix_x [0:1023];
    int pix_y [0:1023];
    int pix_c [0:1023];

    always #5 clk = ~clk;

    pcircle dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .fill       (fill),
        .colour     (colour),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .radius     (radius),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Iteration count of the midpoint loop for radius r.
    function automatic int ref_iters(input int r);
        int ox, oy, crit, n;
        ox = r; oy = 0; crit = 1 - r; n = 0;
        do begin
            n++;
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
        return n;
    endfunction

    // Runs from the edge that sees start until done, logging plotted pixels.
    task automatic run_draw(input bit scramble, output int cycles, output int plots);
        cycles = 0;
        plots  = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) break;
            cycles++;
            if (scramble && cycles == 1) begin
                centre_x = 8'd0; centre_y = 7'd0; radius = 8'd3; colour = 3'd7;
            end
            if (vga_plot) begin
                if (plots < 1024) begin
                    pix_x[plots] = int'(vga_x);
                    pix_y[plots] = int'(vga_y);
                    pix_c[plots] = int'(vga_colour);
                end
                plots++;
            end
        end
        check("draw_done", int'(done), 1);
    endtask

    task automatic release_start();
        start = 1'b0;
        @(negedge clk);
        check("done_clear", int'(done), 0);
    endtask

    task automatic begin_draw(input int c, input int x, input int y, input int r, input bit f);
        colour   = 3'(c);
        centre_x = 8'(x);
        centre_y = 7'(y);
        radius   = 8'(r);
        fill     = f;
        start    = 1'b1;
    endtask

    initial begin
        int cyc, pl, bad, n40, n10, hold, seen;
        int ex40 [8] = '{120, 80, 40, 80, 40, 80, 120, 80};
        int ey40 [8] = '{60, 100, 60, 100, 60, 20, 60, 20};
        int ox2 [16] = '{12, 10, 8, 10, 8, 10, 12, 10, 12, 11, 8, 9, 8, 9, 12, 11};
        int oy2 [16] = '{10, 12, 10, 12, 10, 8, 10, 8, 11, 12, 11, 12, 9, 8, 9, 8};
        int mask [5];
        int emask [5] = '{32'hE00, 32'h1F00, 32'h1F00, 32'h1F00, 32'hE00};

        rst_n = 1'b0; start = 1'b0; fill = 1'b0;
        colour = '0; centre_x = '0; centre_y = '0; radius = '0;
        repeat (3) @(negedge clk);
        check("rst_done", int'(done), 0);
        check("rst_plot", int'(vga_plot), 0);
        check("rst_x", int'(vga_x), 0);
        check("rst_y", int'(vga_y), 0);
        check("rst_colour", int'(vga_colour), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_plot", int'(vga_plot), 0);

        // Outline r=40; inputs scrambled after latching must not matter.
        n40 = ref_iters(40);
        begin_draw(2, 80, 60, 40, 1'b0);
        run_draw(1'b1, cyc, pl);
        check("r40_cycles", cyc, 1 + 8 * n40);
        check("r40_plots", pl, 8 * n40);
        for (int i = 0; i < 8; i++) check("r40_pixel", pix_x[i] * 256 + pix_y[i],
                                          ex40[i] * 256 + ey40[i]);
        bad = 0;
        for (int i = 0; i < pl && i < 1024; i++) if (pix_c[i] != 2) bad++;
        check("r40_colour_bad", bad, 0);

        // Done held while start stays high.
        hold = 0;
        repeat (20) begin
            @(negedge clk);
            if (done && !vga_plot) hold++;
        end
        check("done_hold", hold, 20);
        release_start();

        // Radius 0.
        begin_draw(5, 80, 60, 0, 1'b0);
        run_draw(1'b0, cyc, pl);
        check("r0_cycles", cyc, 9);
        check("r0_plots", pl, 8);
        bad = 0;
        for (int i = 0; i < 8; i++) if (pix_x[i] != 80 || pix_y[i] != 60 || pix_c[i] != 5) bad++;
        check("r0_pixel_bad", bad, 0);
        release_start();

        // Clipping near the origin.
        n10 = ref_iters(10);
        begin_draw(1, 5, 5, 10, 1'b0);
        run_draw(1'b0, cyc, pl);
        check("clip_cycles", cyc, 1 + 8 * n10);
        check("clip_dropped", int'(pl < 8 * n10), 1);
        bad = 0;
        for (int i = 0; i < pl && i < 1024; i++) begin
            if (pix_x[i] >= 160 || pix_y[i] >= 120) bad++;
            if (pix_x[i] == 251 && pix_y[i] == 5) bad++;
        end
        check("clip_offscreen", bad, 0);
        check("clip_p0", pix_x[0] * 256 + pix_y[0], 15 * 256 + 5);
        check("clip_p1", pix_x[1] * 256 + pix_y[1], 5 * 256 + 15);
        check("clip_p2", pix_x[2] * 256 + pix_y[2], 5 * 256 + 15);
        check("clip_p3", pix_x[3] * 256 + pix_y[3], 15 * 256 + 5);
        release_start();

        // Reset during iteration 3 (17th plotted pixel), then a fresh draw.
        begin_draw(3, 80, 60, 40, 1'b0);
        seen = 0;
        for (int i = 0; i < 1000 && seen < 17; i++) begin
            @(negedge clk);
            if (vga_plot) seen++;
        end
        check("pre_reset_seen", seen, 17);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_plot", int'(vga_plot), 0);
        check("mid_rst_done", int'(done), 0);
        rst_n = 1'b1;
        run_draw(1'b0, cyc, pl);
        check("restart_first", pix_x[0] * 256 + pix_y[0], 120 * 256 + 60);
        check("restart_plots", pl, 8 * n40);
        check("restart_cycles", cyc, 1 + 8 * n40);
        release_start();

        // r=2 at (10,10) with fill requested.
        begin_draw(4, 10, 10, 2, 1'b1);
        run_draw(1'b0, cyc, pl);
`ifdef PCIRCLE_FILL_EN
        check("fill_plots", pl, 28);
        check("fill_cycles", cyc, 29);
        for (int r = 0; r < 5; r++) mask[r] = 0;
        bad = 0;
        for (int i = 0; i < pl && i < 1024; i++) begin
            if (pix_y[i] >= 8 && pix_y[i] <= 12 && pix_x[i] < 31)
                mask[pix_y[i] - 8] |= (1 << pix_x[i]);
            else bad++;
        end
        check("fill_outside", bad, 0);
        for (int r = 0; r < 5; r++) check("fill_row_mask", mask[r], emask[r]);
`else
        check("nofill_plots", pl, 16);
        check("nofill_cycles", cyc, 17);
        for (int i = 0; i < 16; i++) check("nofill_pixel", pix_x[i] * 256 + pix_y[i],
                                           ox2[i] * 256 + oy2[i]);
        mask[0] = emask[0];
`endif
        release_start();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
